// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode encoding and carry/flag validity lists
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_XOR  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_LSL  = 4'b0011,
        OP_LSR  = 4'b0100,
        OP_ADD  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_LT   = 4'b0111,
        OP_GT   = 4'b1000,
        OP_EQ   = 4'b1001,
        OP_PASS = 4'b1111
    } alu_op_e;

    // One bit per opcode value: LSL, LSR, ADD, SUB produce a meaningful carry.
    localparam logic [15:0] CARRY_OP_MASK = 16'h0078;
    // LT, GT, EQ produce a meaningful branch flag.
    localparam logic [15:0] FLAG_OP_MASK  = 16'h0380;

    function automatic logic is_carry_op(input logic [3:0] op);
        return CARRY_OP_MASK[op];
    endfunction

    function automatic logic is_flag_op(input logic [3:0] op);
        return FLAG_OP_MASK[op];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with combinational grants
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // last_q: 0 = requester 0 granted most recently, 1 = requester 1
    logic last_q;
    logic last_d;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        last_d = last_q;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        // A grant is only ever given to a high req, so a grant is an acceptance.
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic              cin0,
    input  logic              cin1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_rslt,
    input  logic              alu_cout,
    input  logic              alu_flag,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_rslt,
    output logic              rsp_cout,
    output logic              rsp_flag
);

    logic              iss_valid_q, iss_valid_d;
    logic              iss_id_q,    iss_id_d;
    logic [OP_W-1:0]   iss_op_q,    iss_op_d;
    logic [DATA_W-1:0] iss_a_q,     iss_a_d;
    logic [DATA_W-1:0] iss_b_q,     iss_b_d;
    logic              iss_cin_q,   iss_cin_d;

    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rslt_q,  rsp_rslt_d;
    logic              rsp_cout_q,  rsp_cout_d;
    logic              rsp_flag_q,  rsp_flag_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // Issue stage: capture the winner's operation at acceptance only.
    always_comb begin
        iss_valid_d = gnt0 || gnt1;
        iss_id_d    = iss_id_q;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_cin_d   = iss_cin_q;
        if (gnt1) begin
            iss_id_d  = 1'b1;
            iss_op_d  = op1;
            iss_a_d   = a1;
            iss_b_d   = b1;
            iss_cin_d = cin1;
        end else if (gnt0) begin
            iss_id_d  = 1'b0;
            iss_op_d  = op0;
            iss_a_d   = a0;
            iss_b_d   = b0;
            iss_cin_d = cin0;
        end
    end

    // An idle ALU sees a harmless PASS of zero.
    always_comb begin
        alu_op  = OP_W'(OP_PASS);
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if (iss_valid_q) begin
            alu_op  = iss_op_q;
            alu_a   = iss_a_q;
            alu_b   = iss_b_q;
            alu_cin = iss_cin_q;
        end
    end

    // Response stage: carry and flag are only trusted for opcodes that define them.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_rslt_d  = rsp_rslt_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_flag_d  = rsp_flag_q;
        if (iss_valid_q) begin
            rsp_valid_d[iss_id_q] = 1'b1;
            rsp_rslt_d = alu_rslt;
            rsp_cout_d = is_carry_op(4'(iss_op_q)) ? alu_cout : 1'b0;
            rsp_flag_d = is_flag_op(4'(iss_op_q)) ? alu_flag : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_op_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_cin_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rslt_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_flag_q  <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_cin_q   <= iss_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rslt_q  <= rsp_rslt_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_flag_q  <= rsp_flag_d;
        end
    end

    assign rsp_valid0 = rsp_valid_q[0];
    assign rsp_valid1 = rsp_valid_q[1];
    assign rsp_rslt   = rsp_rslt_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_flag   = rsp_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] op0, op1;
    logic [7:0] a0, a1, b0, b1;
    logic       cin0, cin1;
    logic       gnt0, gnt1;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_cin;
    logic [7:0] alu_rslt;
    logic       alu_cout, alu_flag;
    logic       rsp_valid0, rsp_valid1;
    logic [7:0] rsp_rslt;
    logic       rsp_cout, rsp_flag;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_rslt(alu_rslt), .alu_cout(alu_cout), .alu_flag(alu_flag),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_rslt(rsp_rslt), .rsp_cout(rsp_cout), .rsp_flag(rsp_flag)
    );

    // Architectural meaning of each opcode: {result, carry, flag}, carry/flag 0 where undefined.
    function automatic logic [9:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        logic [7:0] r;
        logic       c, f;
        int         s;
        r = 8'h00; c = 1'b0; f = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a ^ b;
            4'd2:  r = a | b;
            4'd3:  begin r = 8'((int'(a) * 2 + int'(cin)) % 256); c = a >= 8'd128; end
            4'd4:  begin r = 8'(int'(a) / 2 + (cin ? 128 : 0)); c = (a % 2) == 1; end
            4'd5:  begin s = int'(a) + int'(b) + int'(cin); r = 8'(s % 256); c = s > 255; end
            4'd6:  begin s = int'(a) - int'(b) - int'(cin); r = 8'((s + 256) % 256); c = s < 0; end
            4'd7:  f = a < b;
            4'd8:  f = a > b;
            4'd9:  f = a == b;
            4'd15: r = a;
            default: r = 8'h00;
        endcase
        return {r, c, f};
    endfunction

    // The shared ALU: undefined carry/flag are driven to 1 so masking is observable.
    logic [9:0] alu_v;
    always_comb begin
        alu_v    = ref_op(alu_op, alu_a, alu_b, alu_cin);
        alu_rslt = alu_v[9:2];
        alu_cout = (alu_op inside {4'd3, 4'd4, 4'd5, 4'd6}) ? alu_v[1] : 1'b1;
        alu_flag = (alu_op inside {4'd7, 4'd8, 4'd9}) ? alu_v[0] : 1'b1;
    end

    typedef struct {
        int         id;
        logic [7:0] rslt;
        logic       cout;
        logic       flag;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   model_last = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle of stimulus; g reports which requester the model says was accepted (-1 none).
    task automatic drive(input logic r0, input logic [3:0] o0, input logic [7:0] x0,
                         input logic [7:0] y0, input logic c0,
                         input logic r1, input logic [3:0] o1, input logic [7:0] x1,
                         input logic [7:0] y1, input logic c1, output int g);
        logic [9:0] v;
        exp_t       e;
        @(negedge clk);
        req0 = r0; op0 = o0; a0 = x0; b0 = y0; cin0 = c0;
        req1 = r1; op1 = o1; a1 = x1; b1 = y1; cin1 = c1;
        #1;
        if (r0 && r1) g = (model_last == 1) ? 0 : 1;
        else if (r0)  g = 0;
        else if (r1)  g = 1;
        else          g = -1;
        check("gnt0", gnt0, g == 0);
        check("gnt1", gnt1, g == 1);
        if (g >= 0) begin
            v = (g == 0) ? ref_op(o0, x0, y0, c0) : ref_op(o1, x1, y1, c1);
            e.id = g; e.rslt = v[9:2]; e.cout = v[1]; e.flag = v[0]; e.cyc = cyc + 2;
            sb.push_back(e);
            model_last = g;
        end
    endtask

    task automatic one(input logic r0, input logic [3:0] o0, input logic [7:0] x0,
                       input logic [7:0] y0, input logic c0);
        int g;
        drive(r0, o0, x0, y0, c0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0, g);
    endtask

    task automatic one1(input logic [3:0] o1, input logic [7:0] x1, input logic [7:0] y1,
                        input logic c1);
        int g;
        drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1, o1, x1, y1, c1, g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) one(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, {gnt1, gnt0}, 0);
        check({tag, "_rsp_valid"}, {rsp_valid1, rsp_valid0}, 0);
        check({tag, "_rsp_rslt"}, rsp_rslt, 0);
        check({tag, "_rsp_cout_flag"}, {rsp_cout, rsp_flag}, 0);
    endtask

    // Monitor: every response strobe must match the oldest expected operation.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (rsp_valid0 || rsp_valid1) begin
                check("rsp_exclusive", rsp_valid0 && rsp_valid1, 1'b0);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {rsp_valid1, rsp_valid0}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_id", {rsp_valid1, rsp_valid0}, (mon_e.id == 1) ? 2 : 1);
                    check("rsp_rslt", rsp_rslt, mon_e.rslt);
                    check("rsp_cout", rsp_cout, mon_e.cout);
                    check("rsp_flag", rsp_flag, mon_e.flag);
                    check("rsp_latency", cyc, mon_e.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                check("rsp_missing", rsp_valid0 || rsp_valid1, 1'b1);
            end
        end
    end

    logic [3:0] op_tab [12];
    logic       pend0, pend1;
    logic [3:0] p_op0, p_op1;
    logic [7:0] p_a0, p_a1, p_b0, p_b1;
    logic       p_c0, p_c1;

    initial begin
        int g;
        op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15, 4'd10};
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        op0 = 4'd5; op1 = 4'd5; a0 = 8'h11; a1 = 8'h22; b0 = 8'h01; b1 = 8'h02;
        cin0 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b0;

        // Tie straight out of reset: grants 0,1,0,1.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 4'd5, 8'(i), 8'h10, 1'b0, 1'b1, 4'd6, 8'h40, 8'(i), 1'b1, g);
        idle(3);

        one(1'b1, 4'd5, 8'h05, 8'h03, 1'b0);
        idle(3);

        one1(4'd3, 8'h81, 8'h00, 1'b1);
        one1(4'd0, 8'hF0, 8'h3C, 1'b1);
        idle(3);

        one(1'b1, 4'd7, 8'h02, 8'h09, 1'b0);
        one(1'b1, 4'd9, 8'h10, 8'h10, 1'b0);
        one(1'b1, 4'd8, 8'h10, 8'h10, 1'b0);
        idle(3);

        one(1'b1, 4'd5, 8'hF0, 8'h20, 1'b1);
        one(1'b1, 4'd6, 8'h03, 8'h07, 1'b0);
        one(1'b1, 4'd1, 8'hA5, 8'h5A, 1'b0);
        idle(3);

        // Reset between acceptance and response: the operation is dropped.
        one(1'b1, 4'd2, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        sb.delete();
        model_last = 1;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        check("post_reset_rslt", rsp_rslt, 0);
        drive(1'b1, 4'd5, 8'h01, 8'h01, 1'b0, 1'b1, 4'd5, 8'h02, 8'h02, 1'b0, g);
        idle(3);

        // Randomised traffic: a requester holds its operation until accepted.
        pend0 = 1'b0; pend1 = 1'b0;
        p_op0 = 0; p_op1 = 0; p_a0 = 0; p_a1 = 0; p_b0 = 0; p_b1 = 0; p_c0 = 0; p_c1 = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1'b1;
                p_op0 = op_tab[$urandom_range(0, 11)];
                p_a0 = 8'($urandom); p_b0 = 8'($urandom); p_c0 = 1'($urandom);
            end
            if (!pend1 && $urandom_range(0, 3) != 0) begin
                pend1 = 1'b1;
                p_op1 = op_tab[$urandom_range(0, 11)];
                p_a1 = 8'($urandom); p_b1 = 8'($urandom); p_c1 = 1'($urandom);
            end
            drive(pend0, p_op0, p_a0, p_b0, p_c0, pend1, p_op1, p_a1, p_b1, p_c1, g);
            if (g == 0) pend0 = 1'b0;
            if (g == 1) pend1 = 1'b0;
        end
        idle(4);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand and result width.
REQ-002 SHALL have parameter OP_W, default 4, meaning ALU opcode width.
REQ-003 SHALL have port clk, input, 1, the single clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have ports req0/req1, input, 1 each, requester i holds an operation.
REQ-006 SHALL have ports op0/op1 (OP_W), a0/a1 and b0/b1 (DATA_W), cin0/cin1 (1), inputs, the operation of requester i.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each, combinational grant; req_i & gnt_i at a rising edge is an acceptance.
REQ-008 SHALL have ports alu_op (OP_W), alu_a and alu_b (DATA_W), alu_cin (1), outputs, which drive the shared combinational ALU.
REQ-009 SHALL have ports alu_rslt (DATA_W), alu_cout (1) and alu_flag (1), inputs, the ALU result, shift/overflow carry and branch flag.
REQ-010 SHALL have ports rsp_valid0/rsp_valid1, output, 1 each, one-cycle response strobe per requester.
REQ-011 SHALL have ports rsp_rslt (DATA_W), rsp_cout (1) and rsp_flag (1), outputs, the registered response, shared by both requesters.

Function
REQ-012 SHALL assert at most one gnt per cycle, never to a requester whose req is low.
REQ-013 SHALL grant the sole requester when only one req is high, every cycle, including back-to-back.
REQ-014 SHALL grant the requester not most recently granted when both reqs are high; the last-grant pointer updates only on an acceptance.
REQ-015 SHALL keep requester inputs sampled only at acceptance; requesters hold op/a/b/cin stable while req is high and not granted.
REQ-016 SHALL have an issue stage: on acceptance, register iss_valid=1, iss_id, op, a, b, cin; with no acceptance, iss_valid=0 at the next edge.
REQ-017 SHALL drive alu_op/alu_a/alu_b/alu_cin from the issue register when iss_valid=1, else 4'b1111 (pass), 0, 0, 0.
REQ-018 SHALL have a response stage: at each edge with iss_valid=1, register alu_rslt, masked cout, alu_flag, and pulse rsp_valid[iss_id] for exactly one cycle.
REQ-019 SHALL mask cout: rsp_cout = alu_cout for opcodes 0011 (LSL), 0100 (LSR), 0101 (ADD) and 0110 (SUB), else 0 (ALU cout undefined otherwise).
REQ-020 SHALL set rsp_flag = alu_flag only for opcodes 0111 (LT), 1000 (GT) and 1001 (EQ), else 0.
REQ-021 SHALL hold rsp_rslt/rsp_cout/rsp_flag at their last value when no response is issued.
REQ-022 SHALL meet these rates: latency acceptance at edge N -> rsp_valid high during cycle after edge N+1; throughput one operation per cycle; no backpressure on responses.
REQ-023 SHALL never emit rsp_valid0 and rsp_valid1 together.

Reset
REQ-024 SHALL, while reset is high, force gnt0=gnt1=0, iss_valid=0, rsp_valid0=rsp_valid1=0, rsp_rslt=0, rsp_cout=0, rsp_flag=0, last-grant pointer=1 (req0 wins the first tie).
REQ-025 SHALL, on reset mid-operation, drop accepted but unanswered operations with no response after release.
REQ-026 SHALL start arbitration at the first rising edge after reset deasserts.

Structure
REQ-027 SHALL take from shared package alu_pkg: the opcode enum (AND=0000, XOR=0001, OR=0010, LSL=0011, LSR=0100, ADD=0101, SUB=0110, LT=0111, GT=1000, EQ=1001, PASS=1111) and the carry-valid/flag-valid opcode lists.
REQ-028 SHALL put the two-way round-robin grant logic and pointer in sub-module rr_arb2; issue/response stages stay in alu_arbiter.
REQ-029 SHALL contain no ALU instance; the bench and top level connect one alu to the alu_* ports.

Verification
REQ-030 SHALL cover a single request: req0, op=ADD, a=8'h05, b=8'h03 -> gnt0 that cycle; two edges later rsp_valid0=1, rsp_rslt=8'h08, rsp_cout=0.
REQ-031 SHALL cover a contention tie: req0 & req1 held 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp_valid0/rsp_valid1, never together.
REQ-032 SHALL cover carry masking: req1 op=LSL, a=8'h81, cin=1 -> rsp_rslt=8'h03, rsp_cout=1; then op=AND (ALU cout=x) -> rsp_cout=0.
REQ-033 SHALL cover a compare: req0 op=LT, a=8'h02, b=8'h09 -> rsp_flag=1, rsp_rslt=0; op=EQ a=b=8'h10 -> rsp_flag=1; op=GT a=b=8'h10 -> rsp_flag=0.
REQ-034 SHALL cover back-to-back: req0 held 3 cycles with ops ADD/SUB/XOR -> 3 consecutive rsp_valid0 pulses, results in order.
REQ-035 SHALL cover reset mid-flight: accept at edge N, assert reset before edge N+1 -> no rsp_valid after release, all outputs 0, next tie grants req0.
